ram_access_arbiter: RTL and testbench

- Sequences every access to the MPU's shared RAM through the MOV/MOC handshake.
- Arbitrates between two requesters: the CPU port, used by the control unit for fetch, load and store, and the loader port, used for byte-wide preload and debug writes.
- Checks alignment for byte, halfword and word transfers, times out if MOC never arrives, and returns read data with a 4-phase done handshake.

---
 rtl/ram_access_arbiter.sv | 114 +++++++++++
 tb/tb_ram_access_arbiter.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/ram_access_arbiter.sv
// ram_access_arbiter: round-robin CPU/loader access to the shared RAM through the MOV/MOC handshake
// Ports: Clk/Clr clock and synchronous reset; cpu_* CPU request, done and error; ld_* loader
// byte-write request, done and error; rdata read data; ram_* RAM strobe, command and response.
module ram_access_arbiter #(
  parameter int ADDR_W  = 9,
  parameter int TIMEOUT = 15
) (
  input  logic              Clk,
  input  logic              Clr,
  input  logic              cpu_req,
  input  logic              cpu_rw,
  input  logic [1:0]        cpu_type,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [31:0]       cpu_wdata,
  output logic              cpu_done,
  output logic              cpu_err,
  input  logic              ld_req,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [7:0]        ld_wdata,
  output logic              ld_done,
  output logic              ld_err,
  output logic [31:0]       rdata,
  output logic              ram_mov,
  output logic              ram_rw,
  output logic [1:0]        ram_type,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [31:0]       ram_din,
  input  logic [31:0]       ram_dout,
  input  logic              ram_moc
);
  localparam int CW = $clog2(TIMEOUT + 1);
  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, DONE, ERR} state_t;
  state_t r_state, w_next;
  logic r_last, r_own, r_rw, r_mov, r_done, r_err;
  logic [1:0] r_type;
  logic [ADDR_W-1:0] r_addr;
  logic [31:0] r_wdata, r_rdata;
  logic [CW-1:0] r_cnt;
  logic w_req, w_gnt_ld, w_bad, w_own_req, w_exp;
  // r_last=1 means the loader was served last, so the CPU wins the next tie
  assign w_req     = cpu_req | ld_req;
  assign w_gnt_ld  = ld_req & (~cpu_req | ~r_last);
  assign w_bad     = ~w_gnt_ld & ((cpu_type == 2'b11) | ((cpu_type == 2'b01) & cpu_addr[0]) |
                                  ((cpu_type == 2'b10) & (|cpu_addr[1:0])));
  assign w_own_req = r_own ? ld_req : cpu_req;
  assign w_exp     = r_cnt == CW'(TIMEOUT - 1);
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:      w_next = w_req ? (w_bad ? ERR : ISSUE) : IDLE;
      ISSUE:     w_next = WAIT;
      WAIT:      w_next = ram_moc ? DONE : (w_exp ? ERR : WAIT);
      DONE, ERR: w_next = w_own_req ? r_state : IDLE;
      default:   w_next = IDLE;
    endcase
  end
  always_ff @(posedge Clk) begin
    if (Clr) r_state <= IDLE;
    else r_state <= w_next;
  end
  always_ff @(posedge Clk) begin
    if (Clr) begin
      r_last  <= 1'b1;
      r_own   <= 1'b0;
      r_rw    <= 1'b0;
      r_type  <= 2'b00;
      r_addr  <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
      r_cnt   <= '0;
      r_mov   <= 1'b0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: if (w_req) begin
          r_own   <= w_gnt_ld;
          r_last  <= w_gnt_ld;
          r_rw    <= w_gnt_ld ? 1'b0 : cpu_rw;
          r_type  <= w_gnt_ld ? 2'b00 : cpu_type;
          r_addr  <= w_gnt_ld ? ld_addr : cpu_addr;
          r_wdata <= w_gnt_ld ? {24'b0, ld_wdata} : cpu_wdata;
        end
        ISSUE: begin
          r_mov <= 1'b1;
          r_cnt <= '0;
        end
        WAIT: if (ram_moc) begin
          r_mov <= 1'b0;
          if (r_rw) r_rdata <= ram_dout;
        end else begin
          r_cnt <= r_cnt + 1'b1;
          if (w_exp) r_mov <= 1'b0;
        end
        // done/err register one cycle after entering DONE/ERR and drop with the owner's request
        DONE, ERR: begin
          r_done <= w_own_req;
          r_err  <= (r_state == ERR) & w_own_req;
        end
        default: r_mov <= 1'b0;
      endcase
    end
  end
  assign ram_mov  = r_mov;
  assign ram_rw   = r_rw;
  assign ram_type = r_type;
  assign ram_addr = r_addr;
  assign ram_din  = r_wdata;
  assign rdata    = r_rdata;
  assign cpu_done = r_done & ~r_own;
  assign cpu_err  = r_err & ~r_own;
  assign ld_done  = r_done & r_own;
  assign ld_err   = r_err & r_own;
endmodule

// File: tb/tb_ram_access_arbiter.sv
// tb_ram_access_arbiter: scoreboard bench with a RAM responder and a transaction-level reference model
module tb_ram_access_arbiter;
  localparam int AW = 9;
  localparam int TO = 15;
  logic Clk = 1'b0, Clr = 1'b1;
  logic cpu_req = 1'b0, cpu_rw = 1'b0, ld_req = 1'b0;
  logic [1:0] cpu_type = 2'b00;
  logic [AW-1:0] cpu_addr = '0, ld_addr = '0;
  logic [31:0] cpu_wdata = '0, ram_dout = '0;
  logic [7:0] ld_wdata = '0;
  logic ram_moc = 1'b0;
  logic cpu_done, cpu_err, ld_done, ld_err, ram_mov, ram_rw;
  logic [1:0] ram_type;
  logic [AW-1:0] ram_addr;
  logic [31:0] rdata, ram_din;
  ram_access_arbiter #(.ADDR_W(AW), .TIMEOUT(TO)) dut (
    .Clk(Clk), .Clr(Clr),
    .cpu_req(cpu_req), .cpu_rw(cpu_rw), .cpu_type(cpu_type), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_done(cpu_done), .cpu_err(cpu_err),
    .ld_req(ld_req), .ld_addr(ld_addr), .ld_wdata(ld_wdata), .ld_done(ld_done), .ld_err(ld_err),
    .rdata(rdata), .ram_mov(ram_mov), .ram_rw(ram_rw), .ram_type(ram_type), .ram_addr(ram_addr),
    .ram_din(ram_din), .ram_dout(ram_dout), .ram_moc(ram_moc)
  );
  always #5 Clk = ~Clk;
  typedef struct {bit own; bit err; logic [31:0] rd;} exp_t;
  typedef struct {bit rw; logic [1:0] ty; logic [AW-1:0] a; logic [31:0] d; int dly; logic [31:0] dout;} ram_t;
  exp_t sb_q[$];
  ram_t ram_q[$];
  int checks = 0, errors = 0;
  bit m_last_ldr = 1'b1;
  logic [31:0] m_rdata = '0;
  bit aborted = 1'b0;
  function automatic void check(string n, logic [31:0] a, logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", n, a, e, $time);
    end
  endfunction
  task automatic push_cpu(input bit rw, input logic [1:0] ty, input logic [AW-1:0] a,
                          input logic [31:0] w, input int d, input logic [31:0] dout);
    bit bad, err;
    bad = (ty == 2'b11) || (ty == 2'b01 && a[0]) || (ty == 2'b10 && a[1:0] != 2'b00);
    err = bad || d >= TO;
    if (!bad) ram_q.push_back('{rw, ty, a, w, d, dout});
    if (rw && !err) m_rdata = dout;
    sb_q.push_back('{1'b0, err, m_rdata});
  endtask
  task automatic push_ld(input logic [AW-1:0] a, input logic [7:0] w, input int d);
    ram_q.push_back('{1'b0, 2'b00, a, {24'b0, w}, d, 32'h0});
    sb_q.push_back('{1'b1, d >= TO, m_rdata});
  endtask
  task automatic predict(input bit c, input bit l, input bit rw, input logic [1:0] ty,
                         input logic [AW-1:0] ca, input logic [31:0] cw, input logic [AW-1:0] la,
                         input logic [7:0] lw, input int cd, input int ldl, input logic [31:0] dout);
    bit fl;
    fl = (c && l) ? !m_last_ldr : l;
    if (fl) begin
      push_ld(la, lw, ldl);
      if (c) push_cpu(rw, ty, ca, cw, cd, dout);
    end else begin
      push_cpu(rw, ty, ca, cw, cd, dout);
      if (l) push_ld(la, lw, ldl);
    end
    m_last_ldr = (c && l) ? !fl : l;
  endtask
  task automatic serve_one(input bit who);
    int n;
    n = 0;
    while (!(who ? ld_done : cpu_done) && n < 300) begin @(negedge Clk); n++; end
    check(who ? "ld_done_seen" : "cpu_done_seen", 32'(who ? ld_done : cpu_done), 32'd1);
    repeat (2) begin
      @(negedge Clk);
      check(who ? "ld_done_held" : "cpu_done_held", 32'(who ? ld_done : cpu_done), 32'd1);
    end
    if (who) ld_req = 1'b0;
    else cpu_req = 1'b0;
    n = 0;
    while ((who ? ld_done : cpu_done) && n < 10) begin @(negedge Clk); n++; end
    check(who ? "ld_done_release" : "cpu_done_release", 32'(who ? ld_done : cpu_done), 32'd0);
  endtask
  task automatic serve(input bit c, input bit l);
    fork
      begin if (c) serve_one(1'b0); end
      begin if (l) serve_one(1'b1); end
    join
  endtask
  task automatic issue(input bit c, input bit l, input bit rw, input logic [1:0] ty,
                       input logic [AW-1:0] ca, input logic [31:0] cw, input logic [AW-1:0] la,
                       input logic [7:0] lw, input int cd, input int ldl, input logic [31:0] dout);
    predict(c, l, rw, ty, ca, cw, la, lw, cd, ldl, dout);
    @(negedge Clk);
    cpu_rw = rw; cpu_type = ty; cpu_addr = ca; cpu_wdata = cw;
    ld_addr = la; ld_wdata = lw;
    cpu_req = c; ld_req = l;
    serve(c, l);
  endtask
  function automatic int rand_dly();
    int r;
    r = int'($urandom_range(0, 9));
    return r < 6 ? int'($urandom_range(0, 4)) : r == 6 ? TO - 1 : r == 7 ? TO : r == 8 ? TO - 2 : 255;
  endfunction
  task automatic on_done(input bit who);
    exp_t e;
    check("sb_nonempty", 32'(sb_q.size() != 0), 32'd1);
    if (sb_q.size() == 0) return;
    e = sb_q.pop_front();
    check("done_owner", 32'(who), 32'(e.own));
    check("done_err", 32'(who ? ld_err : cpu_err), 32'(e.err));
    check("other_done", 32'(who ? cpu_done : ld_done), 32'd0);
    check("other_err", 32'(who ? cpu_err : ld_err), 32'd0);
    check("rdata", rdata, e.rd);
  endtask
  bit p_cd = 1'b0, p_ld = 1'b0;
  always @(negedge Clk) begin
    if (cpu_done && !p_cd) on_done(1'b0);
    if (ld_done && !p_ld) on_done(1'b1);
    p_cd = cpu_done;
    p_ld = ld_done;
  end
  ram_t cur;
  int mc = 0;
  bit pm = 1'b0;
  always @(negedge Clk) begin
    if (ram_mov && !pm) begin
      check("mov_expected", 32'(ram_q.size() != 0), 32'd1);
      if (ram_q.size() != 0) begin
        cur = ram_q.pop_front();
        check("ram_rw", 32'(ram_rw), 32'(cur.rw));
        check("ram_type", 32'(ram_type), 32'(cur.ty));
        check("ram_addr", 32'(ram_addr), 32'(cur.a));
        check("ram_din", ram_din, cur.d);
      end else cur = '{1'b0, 2'b00, '0, '0, 255, '0};
      mc = 0;
    end
    if (ram_mov) begin
      ram_moc = (mc == cur.dly);
      ram_dout = (mc == cur.dly) ? cur.dout : $urandom;
      mc++;
    end else begin
      if (pm && !aborted) check("mov_cycles", 32'(mc), 32'(cur.dly < TO ? cur.dly + 1 : TO));
      ram_moc = ($urandom_range(0, 3) == 0);
      ram_dout = $urandom;
    end
    pm = ram_mov;
  end
  initial begin
    int n;
    repeat (3) @(negedge Clk);
    check("rst_mov", 32'(ram_mov), 32'd0);
    check("rst_rw", 32'(ram_rw), 32'd0);
    check("rst_type", 32'(ram_type), 32'd0);
    check("rst_addr", 32'(ram_addr), 32'd0);
    check("rst_din", ram_din, 32'd0);
    check("rst_rdata", rdata, 32'd0);
    check("rst_cpu_done", 32'({cpu_done, cpu_err}), 32'd0);
    check("rst_ld_done", 32'({ld_done, ld_err}), 32'd0);
    Clr = 1'b0;
    issue(1, 0, 1, 2'b10, 9'h004, 32'h0, 9'h0, 8'h0, 2, 0, 32'hDEADBEEF);
    issue(0, 1, 0, 2'b00, 9'h0, 32'h0, 9'h010, 8'hA5, 0, 1, 32'h0);
    repeat (4) issue(1, 1, 1, 2'b10, 9'h008, 32'h0, 9'h011, 8'h5A, 1, 0, $urandom);
    issue(1, 0, 1, 2'b01, 9'h003, 32'h0, 9'h0, 8'h0, 0, 0, 32'h11111111);
    issue(1, 0, 0, 2'b10, 9'h006, 32'h77, 9'h0, 8'h0, 0, 0, 32'h0);
    issue(1, 0, 1, 2'b11, 9'h000, 32'h0, 9'h0, 8'h0, 0, 0, 32'h22222222);
    issue(1, 0, 1, 2'b10, 9'h00C, 32'h0, 9'h0, 8'h0, 255, 0, 32'h33333333);
    issue(1, 0, 1, 2'b00, 9'h00D, 32'h0, 9'h0, 8'h0, TO - 1, 0, 32'hCAFEF00D);
    issue(0, 1, 0, 2'b00, 9'h0, 32'h0, 9'h01F, 8'hC3, 0, 255, 32'h0);
    predict(1, 0, 1, 2'b10, 9'h020, 32'h0, 9'h0, 8'h0, 0, 0, 32'h0BADF00D);
    @(negedge Clk);
    cpu_rw = 1'b1; cpu_type = 2'b10; cpu_addr = 9'h020; cpu_req = 1'b1;
    n = 0;
    while (!cpu_done && n < 50) begin @(negedge Clk); n++; end
    check("read_latency", 32'(n), 32'd4);
    serve(1, 0);
    ram_q.push_back('{1'b1, 2'b10, 9'h040, 32'h0, 255, 32'h0});
    @(negedge Clk);
    cpu_rw = 1'b1; cpu_type = 2'b10; cpu_addr = 9'h040; cpu_req = 1'b1;
    n = 0;
    while (!ram_mov && n < 20) begin @(negedge Clk); n++; end
    check("clr_mov_seen", 32'(ram_mov), 32'd1);
    repeat (3) @(negedge Clk);
    ld_req = 1'b1; ld_addr = 9'h055; ld_wdata = 8'h3C;
    @(negedge Clk);
    aborted = 1'b1;
    Clr = 1'b1;
    sb_q.delete();
    ram_q.delete();
    m_last_ldr = 1'b1;
    m_rdata = '0;
    predict(1, 1, 1, 2'b10, 9'h040, 32'h0, 9'h055, 8'h3C, 1, 2, 32'h12345678);
    @(negedge Clk);
    check("clr_mov", 32'(ram_mov), 32'd0);
    check("clr_cpu_done", 32'(cpu_done), 32'd0);
    check("clr_ld_done", 32'(ld_done), 32'd0);
    check("clr_rdata", rdata, 32'd0);
    Clr = 1'b0;
    @(negedge Clk);
    aborted = 1'b0;
    serve(1, 1);
    for (int i = 0; i < 60; i++) begin
      int r;
      logic [1:0] ty;
      logic [AW-1:0] ca, la;
      logic [7:0] lw;
      r = int'($urandom_range(1, 3));
      ty = 2'($urandom_range(0, 3));
      ca = AW'($urandom_range(0, 511));
      if ($urandom_range(0, 1) == 1) ca[1:0] = 2'b00;
      la = AW'($urandom_range(0, 511));
      lw = 8'($urandom_range(0, 255));
      issue(r[0], r[1], $urandom_range(0, 1) == 1, ty, ca, $urandom, la, lw, rand_dly(), rand_dly(), $urandom);
    end
    repeat (3) @(negedge Clk);
    check("sb_drained", 32'(sb_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
